// File: rtl/rom_load_seq_pkg.sv
// rom_load_pkg: shared types and constants for the Xevious ROM download
// sequencer and the ROM region decoder.
//   state_e      : sequencer states
//   region_e     : ROM region index carried on dn_region
//   REGION_BASE  : first byte address of each region
//   REGION_LIMIT : last byte address of each region (inclusive)
package rom_load_pkg;

  localparam logic [16:0] DEF_TOTAL_BYTES = 17'h17000;

  typedef enum logic [2:0] {
    ST_NOROM = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    RG_CPU1 = 3'd0,
    RG_CPU2 = 3'd1,
    RG_CPU3 = 3'd2,
    RG_FG   = 3'd3,
    RG_BG   = 3'd4,
    RG_SPR  = 3'd5,
    RG_PROM = 3'd6,
    RG_NONE = 3'd7
  } region_e;

  typedef logic [16:0] addr17_t;

  localparam int NUM_REGIONS = 7;

  localparam addr17_t REGION_BASE [NUM_REGIONS] = '{
    17'h00000, 17'h04000, 17'h06000, 17'h07000,
    17'h08000, 17'h10000, 17'h16000
  };

  localparam addr17_t REGION_LIMIT [NUM_REGIONS] = '{
    17'h03FFF, 17'h05FFF, 17'h06FFF, 17'h07FFF,
    17'h0FFFF, 17'h15FFF, 17'h16FFF
  };

endpackage

// File: rtl/rom_load_seq_if.sv
// rom_load_seq_if: download bus between hps_io and the core.
//   ioctl_* : raw byte-write traffic from hps_io (driven by master)
//   dn_*    : qualified, registered write traffic towards the core ROMs
//             (driven by slave, the sequencer)
interface rom_load_seq_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [2:0]  dn_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/rom_load_seq_region_decode.sv
// rom_region_decode: purely combinational byte address -> ROM region index.
//   addr_i   : 17-bit ROM byte address
//   region_o : region index (region_e encoding), RG_NONE when unmapped
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [16:0] addr_i,
  output logic [2:0]  region_o
);

  logic [NUM_REGIONS-1:0] hit;

  // Offset-from-base compare: one unsigned test per region, and an address
  // below the base wraps to a large offset so it misses.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
      assign hit[gi] = (addr_i - REGION_BASE[gi]) <= (REGION_LIMIT[gi] - REGION_BASE[gi]);
    end
  endgenerate

  always_comb begin
    region_o = RG_NONE;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) region_o = 3'(i);
    end
  end

endmodule

// File: rtl/rom_load_seq.sv
// rom_load_seq: ROM download qualification and core reset sequencing.
//   clk_sys_i      : system clock
//   reset_n_i      : asynchronous active-low reset
//   user_reset_i   : OSD / button reset, level sensitive
//   bus            : ioctl_* in, dn_* out (slave side)
//   core_reset_o   : active-high core reset
//   rom_ok_o       : last download complete and clean
//   err_overrun_o  : sticky, a write at/after TOTAL_BYTES was seen
//   bytes_loaded_o : accepted byte count of current/last download
module rom_load_seq
  import rom_load_pkg::*;
#(
  parameter logic [16:0] TOTAL_BYTES = DEF_TOTAL_BYTES,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic               clk_sys_i,
  input  logic               reset_n_i,
  input  logic               user_reset_i,
  rom_load_seq_if.slave      bus,
  output logic               core_reset_o,
  output logic               rom_ok_o,
  output logic               err_overrun_o,
  output logic [16:0]        bytes_loaded_o
);

  state_e      state_q, state_d;
  logic        dl_q;
  logic        ureset_q;
  logic [7:0]  hold_q, hold_d;
  logic [16:0] count_q, count_d;
  logic        err_q, err_d;
  logic        ok_q, ok_d;
  logic [16:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;

  logic dl_rise, dl_fall, in_range;

  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign dl_fall  = ~bus.ioctl_download & dl_q;
  // All 25 address bits take part, so aliases above 128K count as overrun.
  assign in_range = bus.ioctl_addr < {8'd0, TOTAL_BYTES};

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    err_d     = err_q;
    ok_d      = ok_q;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    dn_wr_d   = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // Writes are taken in LOAD even in the cycle the download window
        // falls, so a final byte coinciding with the fall is not lost.
        if (bus.ioctl_wr) begin
          if (in_range) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = bus.ioctl_addr[16:0];
            dn_data_d = bus.ioctl_dout;
            count_d   = (count_q == 17'h1FFFF) ? count_q : count_q + 17'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        // Judge completeness on the count including this cycle's write.
        if (dl_fall) begin
          if (count_d == TOTAL_BYTES && !err_d) begin
            state_d = ST_HOLD;
            hold_d  = 8'(RST_HOLD);
            ok_d    = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_HOLD: begin
        if (ureset_q) begin
          hold_d = 8'(RST_HOLD);
        end else if (hold_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_RUN: begin
        if (ureset_q) begin
          state_d = ST_HOLD;
          hold_d  = 8'(RST_HOLD);
        end
      end
      ST_NOROM, ST_FAIL: ;
      default: state_d = ST_NOROM;
    endcase

    // A new download wins over everything else, including user reset.
    if (dl_rise && state_q != ST_LOAD) begin
      state_d = ST_LOAD;
      count_d = 17'd0;
      err_d   = 1'b0;
      ok_d    = 1'b0;
      dn_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_NOROM;
      dl_q      <= 1'b0;
      ureset_q  <= 1'b0;
      hold_q    <= 8'd0;
      count_q   <= 17'd0;
      err_q     <= 1'b0;
      ok_q      <= 1'b0;
      dn_addr_q <= 17'd0;
      dn_data_q <= 8'd0;
      dn_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= bus.ioctl_download;
      // One register stage on user reset aligns its release latency with
      // the download-fall path (both RST_HOLD+2 cycles).
      ureset_q  <= user_reset_i;
      hold_q    <= hold_d;
      count_q   <= count_d;
      err_q     <= err_d;
      ok_q      <= ok_d;
      dn_addr_q <= dn_addr_d;
      dn_data_q <= dn_data_d;
      dn_wr_q   <= dn_wr_d;
    end
  end

  rom_region_decode u_region (
    .addr_i   (dn_addr_q),
    .region_o (bus.dn_region)
  );

  assign bus.dn_addr     = dn_addr_q;
  assign bus.dn_data     = dn_data_q;
  assign bus.dn_wr       = dn_wr_q;
  assign core_reset_o    = (state_q != ST_RUN);
  assign rom_ok_o        = ok_q;
  assign err_overrun_o   = err_q;
  assign bytes_loaded_o  = count_q;

endmodule

// File: tb/tb_rom_load_seq.sv
// tb_rom_load_seq: scoreboard bench for rom_load_seq.
// Main DUT uses a small image size so several complete loads fit in a short
// run; a second DUT with default parameters covers the region map.
module tb_rom_load_seq;
  import rom_load_pkg::*;

  localparam logic [16:0] TB_TOTAL = 17'd64;
  localparam int unsigned TB_HOLD  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, user_reset;
  logic        core_reset, rom_ok, err_overrun;
  logic [16:0] bytes_loaded;
  logic        core_reset_r, rom_ok_r, err_overrun_r;
  logic [16:0] bytes_loaded_r;

  rom_load_seq_if bus ();
  rom_load_seq_if bus_r ();

  rom_load_seq #(.TOTAL_BYTES(TB_TOTAL), .RST_HOLD(TB_HOLD)) dut (
    .clk_sys_i      (clk),
    .reset_n_i      (reset_n),
    .user_reset_i   (user_reset),
    .bus            (bus.slave),
    .core_reset_o   (core_reset),
    .rom_ok_o       (rom_ok),
    .err_overrun_o  (err_overrun),
    .bytes_loaded_o (bytes_loaded)
  );

  rom_load_seq dut_r (
    .clk_sys_i      (clk),
    .reset_n_i      (reset_n),
    .user_reset_i   (1'b0),
    .bus            (bus_r.slave),
    .core_reset_o   (core_reset_r),
    .rom_ok_o       (rom_ok_r),
    .err_overrun_o  (err_overrun_r),
    .bytes_loaded_o (bytes_loaded_r)
  );

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [2:0]  region;
    logic [16:0] count;
    int          cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_rg[$];
  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: one pop per dn_wr, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dn_wr === 1'b1) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected_dn_wr actual addr=%0h required no write", bus.dn_addr);
      end else begin
        e = q_main.pop_front();
        if (bus.dn_addr !== e.addr || bus.dn_data !== e.data || bus.dn_region !== e.region ||
            bytes_loaded !== e.count || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL main_txn actual a=%0h d=%0h r=%0d n=%0h c=%0d required a=%0h d=%0h r=%0d n=%0h c=%0d",
                   bus.dn_addr, bus.dn_data, bus.dn_region, bytes_loaded, cyc_cnt,
                   e.addr, e.data, e.region, e.count, e.cyc);
        end else begin
          $display("txn main a=%0h d=%0h r=%0d n=%0h", e.addr, e.data, e.region, e.count);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_r.dn_wr === 1'b1) begin
      checks++;
      if (q_rg.size() == 0) begin
        errors++;
        $display("FAIL rg_unexpected_dn_wr actual addr=%0h required no write", bus_r.dn_addr);
      end else begin
        e = q_rg.pop_front();
        if (bus_r.dn_addr !== e.addr || bus_r.dn_data !== e.data || bus_r.dn_region !== e.region ||
            bytes_loaded_r !== e.count || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL rg_txn actual a=%0h r=%0d n=%0h c=%0d required a=%0h r=%0d n=%0h c=%0d",
                   bus_r.dn_addr, bus_r.dn_region, bytes_loaded_r, cyc_cnt,
                   e.addr, e.region, e.count, e.cyc);
        end else begin
          $display("txn rg a=%0h r=%0d n=%0h", e.addr, e.region, e.count);
        end
      end
    end
  end

  // Load bytes 0..n-1 into the main DUT, one write every other cycle; the
  // last write coincides with the download fall. When bad_idx matches, two
  // out-of-range writes are injected first. Returns cycles until core_reset
  // drops (60 means it never dropped).
  task automatic load_main(input int n, input int bad_idx, output int rel);
    int acc = 0;
    logic [7:0] d;
    bus.ioctl_download = 1'b1;
    step();
    step();
    for (int i = 0; i < n; i++) begin
      if (i == bad_idx) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = {8'd0, TB_TOTAL};
        step();
        bus.ioctl_addr = 25'h1000000;
        step();
        bus.ioctl_wr   = 1'b0;
        step();
      end
      d = 8'(i) ^ 8'h5A;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      if (i == n - 1) bus.ioctl_download = 1'b0;
      acc++;
      q_main.push_back('{17'(i), d, 3'd0, 17'(acc), cyc_cnt + 1});
      step();
      bus.ioctl_wr = 1'b0;
      if (i != n - 1) step();
    end
    rel = 1;
    while (core_reset !== 1'b0 && rel < 60) begin
      step();
      rel++;
    end
  endtask

  logic [24:0] spot_addr [8] = '{25'h03FFF, 25'h04000, 25'h06000, 25'h07000,
                                 25'h0FFFF, 25'h10000, 25'h16FFF, 25'h17000};
  logic [2:0]  spot_rg   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    int rel;
    reset_n = 1'b0;
    user_reset = 1'b0;
    bus.ioctl_download = 1'b0;   bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0;      bus.ioctl_dout = 8'd0;
    bus_r.ioctl_download = 1'b0; bus_r.ioctl_wr = 1'b0;
    bus_r.ioctl_addr = 25'd0;    bus_r.ioctl_dout = 8'd0;
    #3;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_ok", rom_ok, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_dn_wr", bus.dn_wr, 0);
    chk("rst_dn_addr", bus.dn_addr, 0);
    chk("rst_dn_data", bus.dn_data, 0);
    chk("rst_dn_region", bus.dn_region, 0);
    chk("rst_bytes", bytes_loaded, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Write outside a download window is ignored; stays in NOROM.
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = 25'd5;
    step();
    bus.ioctl_wr = 1'b0;
    repeat (20) step();
    chk("norom_core_reset", core_reset, 1);
    chk("norom_bytes", bytes_loaded, 0);

    // Full load.
    load_main(int'(TB_TOTAL), -1, rel);
    chk("full1_release_cycles", rel, 18);
    chk("full1_bytes", bytes_loaded, 32'(TB_TOTAL));
    chk("full1_rom_ok", rom_ok, 1);
    chk("full1_err", err_overrun, 0);

    // Short by one byte -> FAIL.
    load_main(int'(TB_TOTAL) - 1, -1, rel);
    chk("short_core_reset", core_reset, 1);
    chk("short_rom_ok", rom_ok, 0);
    chk("short_bytes", bytes_loaded, 32'(TB_TOTAL) - 1);

    // Recovery with a full load.
    load_main(int'(TB_TOTAL), -1, rel);
    chk("recover_release_cycles", rel, 18);
    chk("recover_rom_ok", rom_ok, 1);

    // Overrun writes mid-load -> FAIL despite full count.
    load_main(int'(TB_TOTAL), 10, rel);
    chk("ovr_core_reset", core_reset, 1);
    chk("ovr_err", err_overrun, 1);
    chk("ovr_bytes", bytes_loaded, 32'(TB_TOTAL));
    chk("ovr_rom_ok", rom_ok, 0);

    // Good load, then a 5-cycle user reset pulse in RUN.
    load_main(int'(TB_TOTAL), -1, rel);
    chk("full2_release_cycles", rel, 18);
    user_reset = 1'b1;
    repeat (5) step();
    chk("ureset_core_reset_high", core_reset, 1);
    user_reset = 1'b0;
    rel = 0;
    while (core_reset !== 1'b0 && rel < 60) begin
      step();
      rel++;
    end
    chk("ureset_release_cycles", rel, 18);
    chk("ureset_rom_ok", rom_ok, 1);

    // Region map on the default-sized DUT.
    bus_r.ioctl_download = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      bus_r.ioctl_addr = spot_addr[i];
      bus_r.ioctl_dout = 8'(i);
      bus_r.ioctl_wr   = 1'b1;
      if (i < 7) q_rg.push_back('{spot_addr[i][16:0], 8'(i), spot_rg[i], 17'(i + 1), cyc_cnt + 1});
      step();
      bus_r.ioctl_wr = 1'b0;
      step();
    end
    chk("rg_err_overrun", err_overrun_r, 1);
    bus_r.ioctl_download = 1'b0;
    repeat (3) step();
    chk("rg_fail_core_reset", core_reset_r, 1);

    // New download from RUN, then reset_n mid-load with a write in flight.
    bus.ioctl_download = 1'b1;
    step(); step();
    chk("reload_core_reset", core_reset, 1);
    chk("reload_rom_ok_cleared", rom_ok, 0);
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'hC0 + 8'(i);
      bus.ioctl_wr   = 1'b1;
      q_main.push_back('{17'(i), 8'hC0 + 8'(i), 3'd0, 17'(i + 1), cyc_cnt + 1});
      step();
      bus.ioctl_wr = 1'b0;
      step();
    end
    bus.ioctl_addr = 25'd3;
    bus.ioctl_wr   = 1'b1;
    step();
    reset_n = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    chk("midrst_dn_wr", bus.dn_wr, 0);
    chk("midrst_bytes", bytes_loaded, 0);
    chk("midrst_core_reset", core_reset, 1);
    step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("midrst_norom_core_reset", core_reset, 1);
    chk("midrst_norom_bytes", bytes_loaded, 0);

    repeat (3) step();
    chk("main_queue_empty", q_main.size(), 0);
    chk("rg_queue_empty", q_rg.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
